keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix keypad front end for the alarm clock: scans a 4-row by 3-column keypad, debounces press and release, and presents the result as a 4-bit key code. Digits 0–9 are codes 0–9; code 10 means no key. It produces the level-valued `key` bus consumed by the alarm controller FSM, which treats any value other than 10 as a held key.

## Interface
- `SCAN_DIV`, 1000: clock cycles per scan/sample tick; must be ≥ 4.
- `DEBOUNCE_COUNT`, 4: consecutive agreeing tick samples needed to accept a press or a release; must be ≥ 1 and ≤ 15.
- `clock` input 1: system clock; all state is on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `col` input 3: keypad columns, active-low (pulled up, asynchronous to `clock`).
- `row` output 4: row drive, active-low, one-hot-zero.
- `key` output 4: accepted key code 0–9, or 10 when no key.
- `key_strobe` output 1: one-cycle pulse when a new key is accepted.

## Operation
- `col` passes through a 2-flop synchronizer (`col_s`); all decisions use `col_s`.
- The tick counter runs 0..SCAN_DIV-1 and wraps. `tick` is asserted in the cycle where the count is SCAN_DIV-1. All FSM decisions happen only on `tick`.
- Row index `r` is 0..3 and wraps 3→0. `row = ~(4'b0001 << r)`.
- Column select is a priority encode of `~col_s`, lowest column first; `hit` means at least one bit of `col_s` is low.
- Key map for row r, column c:
  - r ≤ 2: code 3r+c+1, giving 1..9.
  - r = 3, c = 1: code 0.
  - r = 3, c = 0 or 2 (the * and # positions): invalid, treated as no hit.
- States and transitions, all evaluated on `tick`:
  - SCAN: on a valid hit, latch `lc` (the encoded column), set `cnt` = 1, and go to DEBOUNCE. If DEBOUNCE_COUNT = 1, go straight to the accept action instead. Otherwise advance `r`.
  - DEBOUNCE: `r` is frozen.
    - If `col_s[lc]` is low and `lc` is still the priority column: `cnt`++. When `cnt` reaches DEBOUNCE_COUNT, accept.
    - Otherwise go to SCAN, advance `r`, and leave `key` unchanged.
  - Accept action: `key` ← code(r, lc), `key_strobe` = 1 for exactly that cycle, go to HELD.
  - HELD: if `col_s[lc]` is high, set `cnt` = 1 and go to RELEASE (or do the release action immediately when DEBOUNCE_COUNT = 1). Otherwise stay. Other columns are ignored.
  - RELEASE: if `col_s[lc]` is high, `cnt`++; at DEBOUNCE_COUNT, do the release action. If it is low, go back to HELD with `cnt` = 0.
  - Release action: `key` ← 10, go to SCAN, advance `r`.
- `key` holds the accepted code throughout HELD and RELEASE. It never changes while in SCAN or DEBOUNCE.
- Multiple keys:
  - Lowest column wins within a row.
  - A second key pressed while in HELD is ignored.
  - After release, the scan resumes from the next row.
- Reset (`reset` low), asynchronous:
  - state = SCAN, `r` = 0, `row` = 4'b1110.
  - `key` = 10, `key_strobe` = 0.
  - tick counter = 0, `cnt` = 0, synchronizer = 3'b111.

## Timing
- `row` changes on the clock edge after a `tick` that advances `r`. The next decision samples that row SCAN_DIV cycles later, which leaves settle and synchronizer time; this is why SCAN_DIV ≥ 4.
- Press latency: from `col` stable low to `key` valid is at most (4 + DEBOUNCE_COUNT) × SCAN_DIV + 2 cycles. It is at least (DEBOUNCE_COUNT − 1) × SCAN_DIV + 3 cycles.
- `key_strobe` and the new `key` value appear in the same cycle, registered on the edge after the accepting `tick`.
- Release latency: from `col` high to `key` = 10 is at most DEBOUNCE_COUNT × SCAN_DIV + 2 cycles.
- Bounce shorter than DEBOUNCE_COUNT consecutive ticks produces no strobe, and `key` stays unchanged.
- All outputs are registered. Outputs have no combinational path from `col`.
- Asserting reset mid-debounce or mid-hold drives `key` to 10 immediately and suppresses any pending strobe.

## Test plan
Use SCAN_DIV = 4 and DEBOUNCE_COUNT = 3 throughout.
- Reset then idle, with `col` = 3'b111 for 100 cycles: `row` cycles 1110→1101→1011→0111→1110 every 4 cycles, `key` = 10 and `key_strobe` = 0 throughout.
- Hold key "5" by pulling `col[1]` low whenever `row` = 1101: exactly one `key_strobe` and `key` = 5. `row` stays frozen at 1101 while held. After release, `key` = 10 within 3 ticks plus 2 cycles.
- Bounce on key "7" (row 2, col 0): press for 2 ticks, release for 1, then hold. The first burst gives no strobe. Exactly one strobe follows the stable hold, with `key` = 7.
- Row 3 positions: `col[0]` low on row 3 gives no strobe and scanning continues. `col[1]` low on row 3 gives `key` = 0 with one strobe.
- Two keys in one row: `col[2]` and `col[0]` low on row 0 together give `key` = 1. A key "9" pressed while "1" is held is ignored.
- Reset asserted while HELD with `key` = 4: `key` = 10, `row` = 1110 and `key_strobe` = 0 asynchronously, and scanning restarts from row 0 after reset is released.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle of the scanner: column sense in, row drive and key result out.
interface keypad_scanner_if;
   logic [2:0] col;         // active-low column sense, asynchronous to clock
   logic [3:0] row;         // active-low one-hot row drive
   logic [3:0] key;         // accepted key code 0..9, 10 = no key
   logic       key_strobe;  // one-cycle pulse on a newly accepted key

   // scanner side: senses columns, drives rows and the key result
   modport master (input col, output row, key, key_strobe);
   // keypad / consumer side
   modport slave  (output col, input row, key, key_strobe);
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with press/release debounce. Emits a level key code
// (0..9, 10 = none) plus a one-cycle strobe when a new key is accepted.
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,  // clocks per scan/sample tick, >= 4
   parameter int DEBOUNCE_COUNT = 4      // agreeing ticks to accept, 1..15
) (
   input  logic             clock,
   input  logic             reset,      // async, active low
   keypad_scanner_if.master kp
);
   localparam int         TW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [3:0] NO_KEY = 4'd10;
   localparam logic [3:0] DB     = 4'(DEBOUNCE_COUNT);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t        state, state_n;
   logic [2:0]    col_m, col_s;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [1:0]    r, r_n, lc, lc_n, pc;
   logic [3:0]    cnt, cnt_n, key_n;
   logic          strobe_n, hit, vhit, lc_down, lc_prio;

   // rows 0..2 map to 1..9, row 3 centre column is 0; * and # never reach here
   function automatic logic [3:0] key_code(input logic [1:0] rr, input logic [1:0] cc);
      if (rr == 2'd3) return 4'd0;
      return 4'(rr) * 4'd3 + 4'(cc) + 4'd1;
   endfunction

   // two-flop synchronizer for the asynchronous column inputs; idles released
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_m <= 3'b111;
         col_s <= 3'b111;
      end else begin
         col_m <= kp.col;
         col_s <= col_m;
      end
   end

   // free-running scan divider; tick marks the last count of each period
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)    tcnt <= '0;
      else if (tick) tcnt <= '0;
      else           tcnt <= tcnt + 1'b1;
   end

   assign tick = (tcnt == TW'(SCAN_DIV - 1));

   // column priority encode (lowest pulled-low column wins) and hit qualification
   always_comb begin
      pc = 2'd2;
      if (!col_s[0])      pc = 2'd0;
      else if (!col_s[1]) pc = 2'd1;
      hit     = ~&col_s;
      // * and # on row 3 behave as if nothing were pressed
      vhit    = hit && !(r == 2'd3 && pc != 2'd1);
      lc_down = !col_s[lc];
      lc_prio = hit && (pc == lc);
   end

   // scan / debounce / hold / release decisions, only ever taken on tick
   always_comb begin
      state_n  = state;
      r_n      = r;
      lc_n     = lc;
      cnt_n    = cnt;
      key_n    = kp.key;
      strobe_n = 1'b0;
      if (tick) begin
         case (state)
            SCAN: begin
               if (vhit) begin
                  lc_n = pc;
                  if (DB == 4'd1) begin
                     key_n    = key_code(r, pc);
                     strobe_n = 1'b1;
                     state_n  = HELD;
                  end else begin
                     cnt_n   = 4'd1;
                     state_n = DEBOUNCE;
                  end
               end else begin
                  r_n = r + 2'd1;
               end
            end
            DEBOUNCE: begin
               // must stay down and stay the winning column to keep counting
               if (lc_down && lc_prio) begin
                  cnt_n = cnt + 4'd1;
                  if (cnt + 4'd1 == DB) begin
                     key_n    = key_code(r, lc);
                     strobe_n = 1'b1;
                     state_n  = HELD;
                  end
               end else begin
                  state_n = SCAN;
                  r_n     = r + 2'd1;
               end
            end
            HELD: begin
               // only the latched column matters; other keys are ignored
               if (!lc_down) begin
                  if (DB == 4'd1) begin
                     key_n   = NO_KEY;
                     state_n = SCAN;
                     r_n     = r + 2'd1;
                  end else begin
                     cnt_n   = 4'd1;
                     state_n = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (!lc_down) begin
                  cnt_n = cnt + 4'd1;
                  if (cnt + 4'd1 == DB) begin
                     key_n   = NO_KEY;
                     state_n = SCAN;
                     r_n     = r + 2'd1;
                  end
               end else begin
                  cnt_n   = 4'd0;
                  state_n = HELD;
               end
            end
            default: state_n = SCAN;
         endcase
      end
   end

   // state and registered outputs; row is decoded from the next row index so it
   // changes on the same edge as r
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= SCAN;
         r             <= 2'd0;
         lc            <= 2'd0;
         cnt           <= 4'd0;
         kp.key        <= NO_KEY;
         kp.key_strobe <= 1'b0;
         kp.row        <= 4'b1110;
      end else begin
         state         <= state_n;
         r             <= r_n;
         lc            <= lc_n;
         cnt           <= cnt_n;
         kp.key        <= key_n;
         kp.key_strobe <= strobe_n;
         kp.row        <= ~(4'b0001 << r_n);
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a physical keypad model pulls columns low for
// pressed keys on the driven row; expected values are hand-derived constants.
module tb_keypad_scanner;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [3:0][2:0] pressed;   // [row][col] switch closed
   logic [2:0]      col_drv;
   int n_chk  = 0;
   int n_fail = 0;
   int n_strobe = 0;
   int s0;
   bit saw_r0;
   logic [3:0] row_tbl [4];

   keypad_scanner_if kif ();

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_COUNT(3)) dut (
      .clock (clock),
      .reset (reset),
      .kp    (kif)
   );

   always #5 clock = ~clock;

   // keypad matrix: a closed switch shorts its column to the active (low) row
   always_comb begin
      col_drv = 3'b111;
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 3; cc++)
            if (!kif.row[rr] && pressed[rr][cc]) col_drv[cc] = 1'b0;
   end
   assign kif.col = col_drv;

   always @(negedge clock) if (kif.key_strobe) n_strobe++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_press(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clock);
         if (kif.key != 4'd10) break;
      end
   endtask

   task automatic wait_clear(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clock);
         if (kif.key == 4'd10) break;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      row_tbl[0] = 4'b1110; row_tbl[1] = 4'b1101;
      row_tbl[2] = 4'b1011; row_tbl[3] = 4'b0111;
      pressed = '0;
      reset   = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_key", kif.key, 10);
      chk("rst_row", kif.row, 4'b1110);
      chk("rst_strobe", kif.key_strobe, 0);

      // idle scan: row advances every 4 cycles, no key activity
      reset = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         chk("idle_row", kif.row, row_tbl[(k / 4) % 4]);
         chk("idle_key", kif.key, 10);
         chk("idle_strobe", kif.key_strobe, 0);
      end

      // key 5: row 1, col 1
      s0 = n_strobe;
      pressed[1][1] = 1'b1;
      wait_press(30);
      chk("k5_key", kif.key, 5);
      chk("k5_strobe_pulse", kif.key_strobe, 1);
      repeat (40) @(negedge clock);
      #1;
      chk("k5_hold_key", kif.key, 5);
      chk("k5_row_frozen", kif.row, 4'b1101);
      chk("k5_one_strobe", n_strobe - s0, 1);
      pressed = '0;
      wait_clear(14);
      chk("k5_release_key", kif.key, 10);
      chk("k5_next_row", kif.row, 4'b1011);
      repeat (10) @(negedge clock);
      #1;
      chk("k5_strobe_total", n_strobe - s0, 1);

      // bounce on key 7: catch row 2 as it becomes active
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (kif.row == 4'b1011) break;
      end
      while (kif.row == 4'b1011) @(negedge clock);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (kif.row == 4'b1011) break;
      end
      chk("b7_row2_seen", kif.row, 4'b1011);
      s0 = n_strobe;
      pressed[2][0] = 1'b1;       // low for two ticks
      repeat (8) @(negedge clock);
      pressed = '0;               // high at the third tick
      repeat (4) @(negedge clock);
      #1;
      chk("b7_no_strobe", n_strobe - s0, 0);
      chk("b7_no_key", kif.key, 10);
      pressed[2][0] = 1'b1;       // stable hold
      wait_press(30);
      chk("b7_key", kif.key, 7);
      repeat (8) @(negedge clock);
      #1;
      chk("b7_one_strobe", n_strobe - s0, 1);
      pressed = '0;
      wait_clear(14);
      chk("b7_release", kif.key, 10);

      // row 3: * is ignored and scanning continues, centre key is 0
      s0 = n_strobe;
      saw_r0 = 1'b0;
      pressed[3][0] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (kif.row == 4'b1110) saw_r0 = 1'b1;
      end
      #1;
      chk("star_no_strobe", n_strobe - s0, 0);
      chk("star_no_key", kif.key, 10);
      chk("star_scanning", saw_r0, 1);
      pressed = '0;
      pressed[3][1] = 1'b1;
      wait_press(30);
      chk("k0_key", kif.key, 0);
      repeat (8) @(negedge clock);
      #1;
      chk("k0_one_strobe", n_strobe - s0, 1);
      pressed = '0;
      wait_clear(14);
      chk("k0_release", kif.key, 10);

      // two keys on row 0: lowest column (key 1) wins; key 9 during hold ignored
      s0 = n_strobe;
      pressed[0][0] = 1'b1;
      pressed[0][2] = 1'b1;
      wait_press(30);
      chk("k1_key", kif.key, 1);
      pressed[2][2] = 1'b1;
      repeat (40) @(negedge clock);
      #1;
      chk("k1_hold_with_9", kif.key, 1);
      chk("k1_row_frozen", kif.row, 4'b1110);
      chk("k1_one_strobe", n_strobe - s0, 1);
      pressed = '0;
      wait_clear(14);
      chk("k1_release", kif.key, 10);
      chk("k1_next_row", kif.row, 4'b1101);

      // reset while holding key 4 (row 1, col 0)
      pressed[1][0] = 1'b1;
      wait_press(30);
      chk("k4_key", kif.key, 4);
      @(negedge clock);
      #1 reset = 1'b0;
      #1;
      chk("arst_key", kif.key, 10);
      chk("arst_row", kif.row, 4'b1110);
      chk("arst_strobe", kif.key_strobe, 0);
      pressed = '0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         chk("restart_row", kif.row, (k < 4) ? 4'b1110 : 4'b1101);
         chk("restart_key", kif.key, 10);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
